// File: rtl/zx_mem_arbiter.sv
// Video SRAM scheduler: vid > cpu > aux (aux promoted after AUX_MAX_WAIT losses); 2-cycle read, 3-cycle write.
// Grant (ack) is issued in the decision cycle, read data 3 cycles later; requesters hold req until acked.
module zx_mem_arbiter #(
   parameter int AW           = 19,
   parameter int AUX_MAX_WAIT = 4
) (
   input  logic          clk28,
   input  logic          rst,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic          vid_valid,
   output logic [7:0]    vid_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_ack,
   output logic          cpu_valid,
   output logic [7:0]    cpu_rdata,
   input  logic          aux_req,
   input  logic          aux_we,
   input  logic [AW-1:0] aux_addr,
   input  logic [7:0]    aux_wdata,
   output logic          aux_ack,
   output logic          aux_valid,
   output logic [7:0]    aux_rdata,
   output logic [AW-1:0] va,
   output logic [7:0]    vd_o,
   output logic          vd_oe,
   input  logic [7:0]    vd_i,
   output logic          n_vrd,
   output logic          n_vwr
);

   typedef enum logic [2:0] {IDLE, R1, R2, W1, W2, W3} state_t;
   typedef enum logic [1:0] {P_VID, P_CPU, P_AUX} port_t;

   typedef struct packed {
      port_t         port;
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    wdata;
   } acc_t;

   localparam logic [3:0] WAIT_MAX = 4'(AUX_MAX_WAIT);

   state_t        state, state_nxt;
   acc_t          cur, cur_nxt;
   logic [3:0]    aux_wait, aux_wait_nxt;
   logic          decide, aux_urgent;
   logic          gnt_vid, gnt_cpu, gnt_aux;
   logic          rd_done;
   logic [AW-1:0] va_nxt;
   logic [7:0]    vd_o_nxt;
   logic          vd_oe_nxt, n_vrd_nxt, n_vwr_nxt;

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cur      <= '0;
         aux_wait <= '0;
      end else begin
         state    <= state_nxt;
         cur      <= cur_nxt;
         aux_wait <= aux_wait_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cur_nxt      = cur;
      aux_wait_nxt = aux_wait;
      gnt_vid      = 1'b0;
      gnt_cpu      = 1'b0;
      gnt_aux      = 1'b0;
      decide       = (state == IDLE) || (state == R2) || (state == W3);
      aux_urgent   = aux_req && (aux_wait == WAIT_MAX);
      if (decide) begin
         if (vid_req)         gnt_vid = 1'b1;
         else if (aux_urgent) gnt_aux = 1'b1;
         else if (cpu_req)    gnt_cpu = 1'b1;
         else if (aux_req)    gnt_aux = 1'b1;

         if (gnt_vid) begin
            cur_nxt.port  = P_VID;
            cur_nxt.we    = 1'b0;
            cur_nxt.addr  = vid_addr;
            cur_nxt.wdata = '0;
         end
         if (gnt_cpu) begin
            cur_nxt.port  = P_CPU;
            cur_nxt.we    = cpu_we;
            cur_nxt.addr  = cpu_addr;
            cur_nxt.wdata = cpu_wdata;
         end
         if (gnt_aux) begin
            cur_nxt.port  = P_AUX;
            cur_nxt.we    = aux_we;
            cur_nxt.addr  = aux_addr;
            cur_nxt.wdata = aux_wdata;
         end

         // Only a cpu win over a waiting aux counts as a lost arbitration.
         if (gnt_aux || !aux_req)
            aux_wait_nxt = '0;
         else if (gnt_cpu && (aux_wait != WAIT_MAX))
            aux_wait_nxt = aux_wait + 4'd1;

         if (gnt_vid || gnt_cpu || gnt_aux)
            state_nxt = cur_nxt.we ? W1 : R1;
         else
            state_nxt = IDLE;
      end else begin
         case (state)
            R1:      state_nxt = R2;
            W1:      state_nxt = W2;
            W2:      state_nxt = W3;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Bus pins are decoded from the next state so every strobe leaves a flop.
   always_comb begin
      rd_done   = (state == R2);
      va_nxt    = cur_nxt.addr;
      vd_o_nxt  = (state_nxt == W1) ? cur_nxt.wdata : vd_o;
      vd_oe_nxt = (state_nxt == W1) || (state_nxt == W2) || (state_nxt == W3);
      n_vrd_nxt = !((state_nxt == R1) || (state_nxt == R2));
      n_vwr_nxt = (state_nxt != W2);
   end

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         va        <= '0;
         vd_o      <= '0;
         vd_oe     <= 1'b0;
         n_vrd     <= 1'b1;
         n_vwr     <= 1'b1;
         vid_valid <= 1'b0;
         cpu_valid <= 1'b0;
         aux_valid <= 1'b0;
         vid_rdata <= '0;
         cpu_rdata <= '0;
         aux_rdata <= '0;
      end else begin
         va        <= va_nxt;
         vd_o      <= vd_o_nxt;
         vd_oe     <= vd_oe_nxt;
         n_vrd     <= n_vrd_nxt;
         n_vwr     <= n_vwr_nxt;
         vid_valid <= rd_done && (cur.port == P_VID);
         cpu_valid <= rd_done && (cur.port == P_CPU);
         aux_valid <= rd_done && (cur.port == P_AUX);
         if (rd_done && (cur.port == P_VID)) vid_rdata <= vd_i;
         if (rd_done && (cur.port == P_CPU)) cpu_rdata <= vd_i;
         if (rd_done && (cur.port == P_AUX)) aux_rdata <= vd_i;
      end
   end

   assign vid_ack = gnt_vid && !rst;
   assign cpu_ack = gnt_cpu && !rst;
   assign aux_ack = gnt_aux && !rst;

endmodule
